bcd_to_binary_sequential: RTL and testbench

- Iterative BCD-to-binary decoder, one reverse double-dabble step per clock.
- Inverse of the combinational binary-to-BCD encoder in the encoding/bcd library.
- Used where a wide BCD value (display, keypad, decimal config registers) needs decoding without a deep combinational subtract chain.
- Valid/ready handshake on both sides; one conversion in flight at a time.

---
 rtl/bcd_to_binary_sequential.sv | 133 +++++++++++++
 tb/tb_bcd_to_binary_sequential.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_binary_sequential.sv
// Iterative BCD-to-binary decoder: one reverse double-dabble step per clock.
// Optional macro BCD_TO_BINARY_DIGIT_CHECK_EN adds a digit-range checker
// that drives output_invalid; without it output_invalid is tied to 0.
module bcd_to_binary_sequential #(
    parameter int unsigned NUMBER_DIGITS = 3,
    parameter int unsigned WIDTH_BCD     = NUMBER_DIGITS * 4,
    parameter int unsigned WIDTH_BINARY  = 10
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    input_valid,
    output logic                    input_ready,
    input  logic [WIDTH_BCD-1:0]    input_bcd,
    output logic                    output_valid,
    input  logic                    output_ready,
    output logic [WIDTH_BINARY-1:0] output_binary,
    output logic                    output_invalid
);

    localparam int unsigned WidthScratch = WIDTH_BCD + WIDTH_BINARY;
    localparam int unsigned WidthCount   = $clog2(WIDTH_BINARY + 1);

    typedef enum logic [1:0] {
        StIdle,
        StConvert,
        StDone
    } state_e;

    state_e                  state_q, state_d;
    logic [WidthScratch-1:0] scratch_q, scratch_d;
    logic [WidthScratch-1:0] step;
    logic [WidthCount-1:0]   count_q, count_d;
    logic [3:0]              digit;

    // One iteration: shift right, then pull every bcd digit >= 8 down by 3.
    always_comb begin
        step  = scratch_q >> 1;
        digit = '0;
        for (int i = 0; i < NUMBER_DIGITS; i++) begin
            digit = step[WIDTH_BINARY + 4 * i +: 4];
            if (digit >= 4'd8) begin
                step[WIDTH_BINARY + 4 * i +: 4] = digit - 4'd3;
            end
        end
    end

    // FSM next-state, datapath update and handshake outputs.
    always_comb begin
        state_d       = state_q;
        scratch_d     = scratch_q;
        count_d       = count_q;
        input_ready   = 1'b0;
        output_valid  = 1'b0;
        output_binary = '0;
        unique case (state_q)
            StIdle: begin
                input_ready = 1'b1;
                if (input_valid) begin
                    scratch_d = {input_bcd, {WIDTH_BINARY{1'b0}}};
                    count_d   = '0;
                    state_d   = StConvert;
                end
            end
            StConvert: begin
                scratch_d = step;
                count_d   = count_q + 1'b1;
                if (count_q == WidthCount'(WIDTH_BINARY - 1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                output_valid  = 1'b1;
                output_binary = scratch_q[WIDTH_BINARY-1:0];
                if (output_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, scratch and counter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            scratch_q <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            scratch_q <= scratch_d;
            count_q   <= count_d;
        end
    end

`ifdef BCD_TO_BINARY_DIGIT_CHECK_EN
    logic invalid_q, invalid_d;
    logic bad_digit;

    // Any input digit in the 10..15 range.
    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < NUMBER_DIGITS; i++) begin
            if (input_bcd[4 * i +: 4] > 4'd9) begin
                bad_digit = 1'b1;
            end
        end
    end

    // Flag captured on accept, held through the conversion, dropped on handshake.
    always_comb begin
        invalid_d = invalid_q;
        if (state_q == StIdle) begin
            invalid_d = input_valid & bad_digit;
        end else if (state_q == StDone && output_ready) begin
            invalid_d = 1'b0;
        end
    end

    // Invalid-digit flag register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            invalid_q <= 1'b0;
        end else begin
            invalid_q <= invalid_d;
        end
    end

    assign output_invalid = output_valid & invalid_q;
`else
    assign output_invalid = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_to_binary_sequential.sv
module tb_bcd_to_binary_sequential;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        input_valid = 1'b0;
    logic        input_ready;
    logic [11:0] input_bcd = '0;
    logic        output_valid;
    logic        output_ready = 1'b0;
    logic [9:0]  output_binary;
    logic        output_invalid;

    typedef struct {
        logic [9:0] value;
        logic       invalid;
        bit         check_value;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   n_in = 0;
    int   n_out = 0;

    bcd_to_binary_sequential dut (
        .clock         (clock),
        .reset         (reset),
        .input_valid   (input_valid),
        .input_ready   (input_ready),
        .input_bcd     (input_bcd),
        .output_valid  (output_valid),
        .output_ready  (output_ready),
        .output_binary (output_binary),
        .output_invalid(output_invalid)
    );

    always #5 clock = ~clock;

    function automatic logic [9:0] ref_decode(input logic [11:0] bcd);
        int v;
        v = int'(bcd[11:8]) * 100 + int'(bcd[7:4]) * 10 + int'(bcd[3:0]);
        return v[9:0];
    endfunction

    function automatic logic ref_bad(input logic [11:0] bcd);
        return (bcd[11:8] > 4'd9) || (bcd[7:4] > 4'd9) || (bcd[3:0] > 4'd9);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait for input_ready, drive one-cycle valid, push expectation at the accept edge.
    task automatic send(input logic [11:0] bcd, input bit check_value);
        exp_t e;
        int   n;
        n = 0;
        while (!input_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("input_ready_before_send", {31'd0, input_ready}, 32'd1);
        input_valid = 1'b1;
        input_bcd   = bcd;
        e.value       = ref_decode(bcd);
`ifdef BCD_TO_BINARY_DIGIT_CHECK_EN
        e.invalid     = ref_bad(bcd);
`else
        e.invalid     = 1'b0;
`endif
        e.check_value = check_value;
        @(posedge clock);
        sb.push_back(e);
        n_in++;
        @(negedge clock);
        input_valid = 1'b0;
    endtask

    // Full transaction: send, wait for result, stall, handshake. Ends on a negedge.
    task automatic convert(input logic [11:0] bcd, input int stall, input bit check_value);
        exp_t       e;
        int         lat;
        logic [9:0] held;
        send(bcd, check_value);
        lat = 0;
        while (!output_valid && lat < 200) begin
            @(negedge clock);
            lat++;
        end
        check("latency", lat, 32'd10);
        if (sb.size() == 0) begin
            check("scoreboard_nonempty", 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        if (!output_valid) return;
        n_out++;
        if (e.check_value) check("output_binary", {22'd0, output_binary}, {22'd0, e.value});
        check("output_invalid", {31'd0, output_invalid}, {31'd0, e.invalid});
        held = output_binary;
        for (int k = 0; k < stall; k++) begin
            // Competing input while busy must be ignored.
            input_valid = 1'b1;
            input_bcd   = 12'h999;
            @(negedge clock);
            check("hold_valid", {31'd0, output_valid}, 32'd1);
            check("hold_binary", {22'd0, output_binary}, {22'd0, held});
            check("hold_input_ready", {31'd0, input_ready}, 32'd0);
        end
        input_valid  = 1'b0;
        output_ready = 1'b1;
        @(negedge clock);
        output_ready = 1'b0;
        check("post_handshake_valid", {31'd0, output_valid}, 32'd0);
        check("post_handshake_ready", {31'd0, input_ready}, 32'd1);
    endtask

    initial begin
        // Reset values while reset is held.
        #1;
        check("reset_input_ready", {31'd0, input_ready}, 32'd1);
        check("reset_output_valid", {31'd0, output_valid}, 32'd0);
        check("reset_output_binary", {22'd0, output_binary}, 32'd0);
        check("reset_output_invalid", {31'd0, output_invalid}, 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Directed values.
        convert(12'h255, 0, 1'b1);
        convert(12'h999, 0, 1'b1);
        convert(12'h000, 0, 1'b1);
        convert(12'h001, 0, 1'b1);

        // Backpressure for 20 cycles.
        convert(12'h128, 20, 1'b1);

        // Asynchronous reset mid-conversion.
        send(12'h777, 1'b1);
        repeat (4) @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("midreset_input_ready", {31'd0, input_ready}, 32'd1);
        check("midreset_output_valid", {31'd0, output_valid}, 32'd0);
        check("midreset_output_binary", {22'd0, output_binary}, 32'd0);
        check("midreset_output_invalid", {31'd0, output_invalid}, 32'd0);
        if (sb.size() > 0) begin
            void'(sb.pop_back());
            n_in--;
        end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("post_reset_output_valid", {31'd0, output_valid}, 32'd0);
        convert(12'h042, 0, 1'b1);

        // Invalid digit: value unspecified, timing and flag checked.
        convert(12'h1A3, 2, 1'b0);
        convert(12'h103, 0, 1'b1);

        // Sweep with random stalls, back-to-back issue.
        for (int n = 0; n < 1000; n++) begin
            logic [11:0] b;
            b = {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
            convert(b, int'($urandom_range(0, 3)), 1'b1);
        end

        check("scoreboard_empty", sb.size(), 32'd0);
        check("results_count", n_out, n_in);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
